riscv_ifetch: RTL and testbench
===============================

# riscv_ifetch

Instruction fetch stage for the 64-bit RISC-V core. It owns the fetch PC, issues word requests to instruction memory, and buffers the returned instructions with their PCs in a small queue. The queue feeds decode, where the opcode and immediate fields are extracted. A redirect input from execute (taken branch) flushes the queue and discards the in-flight response.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset. Bits [1:0] must be 0.
- `DEPTH`, default 2: instruction queue entries. Power of two, ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  64  fetch byte address; bits [1:0] always 0.
- `imem_ready_i`  in  1  memory accepts the request when `imem_req_o & imem_ready_i`.
- `imem_rvalid_i`  in  1  response valid, at the earliest 1 cycle after acceptance.
- `imem_rdata_i`  in  32  instruction word.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_pc_i`  in  64  new fetch PC; bits [1:0] are ignored and treated as 0.
- `instr_valid_o`  out  1  queue head valid.
- `instr_o`  out  32  queue head instruction.
- `instr_pc_o`  out  64  PC of the queue head.
- `instr_ready_i`  in  1  decode consumes the head when `instr_valid_o & instr_ready_i`.

## Operation
- Registers:
  - `fetch_pc` (64 bits).
  - FSM state.
  - Queue: circular buffer of {pc, instr}, read/write pointers, `count` of 0..DEPTH.
  - `req_pc`: the PC of the outstanding request.
- At most one outstanding memory request.
- FSM states:
  - RUN: no outstanding request.
  - WAIT: outstanding request; its response is kept.
  - DROP: outstanding request; its response is discarded.
- `imem_req_o` = `rst_ni & state==RUN & ~redirect_i & (count < DEPTH)`.
  - Space is checked against `count` only. A request is issued only from RUN, so its response always has a slot.
- `imem_addr_o` = `fetch_pc`.
- Transitions, without redirect:
  - RUN, on accept: `req_pc` <= `fetch_pc`; `fetch_pc` <= `fetch_pc` + 4 (mod 2^64, wraps); go to WAIT.
  - WAIT, on `imem_rvalid_i`: push {`req_pc`, `imem_rdata_i`}; go to RUN.
  - DROP, on `imem_rvalid_i`: discard the data; go to RUN.
- `redirect_i` has priority over everything else:
  - `fetch_pc` <= {`redirect_pc_i`[63:2], 2'b00}.
  - `count` and pointers are cleared.
  - No request is issued in that cycle.
  - State: RUN→RUN; WAIT→DROP; DROP→DROP.
  - In WAIT or DROP with `imem_rvalid_i` in the same cycle: the response is discarded and the state goes to RUN.
- `instr_valid_o` = `(count != 0) & ~redirect_i`. A head cannot be consumed in a redirect cycle.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `imem_rvalid_i` while in RUN is a protocol error: ignored, no state change.
- Queue full (`count == DEPTH`): no new request. A response still pending in WAIT cannot occur in this case, by construction.

## Timing
- While `rst_ni` is low, all outputs are held at:
  - `imem_req_o` = 0, `instr_valid_o` = 0.
  - `imem_addr_o` = `RESET_PC`.
  - `instr_o` = 0, `instr_pc_o` = 0.
- The first request is issued in the first cycle after `rst_ni` goes high.
- Reset asserted mid-operation wins over every other event. An outstanding response arriving after reset is ignored, because the state is RUN.
- With `imem_ready_i` = 1 and the response one cycle after acceptance:
  - Request accepted at cycle N; `imem_rvalid_i` at N+1.
  - `instr_valid_o` high at N+2. Queue outputs are registered.
- Steady-state throughput: 1 instruction per 2 cycles (one outstanding request).
- After a redirect at cycle R:
  - From RUN: the first request to the new PC is at R+1.
  - From WAIT or DROP: the new request is issued in the cycle after the stale response.
- `imem_req_o` must stay stable until accepted, except that a redirect withdraws it.

## Test plan
- Reset and boot: `RESET_PC` = 64'h1000, memory with zero wait states returning 32'h00500093 → `imem_addr_o` sequence 1000, 1004, 1008; head {1000, 00500093} valid 2 cycles after the first accept.
- Back-pressure: `instr_ready_i` = 0, DEPTH = 2 → exactly 2 entries are pushed, then `imem_req_o` stays 0. Raising `instr_ready_i` drains PC 1000 then 1004, in order, and fetch resumes at 1008.
- Redirect with an outstanding request: redirect to 64'h2002 while in WAIT → the stale response is dropped, the queue is empty, and the next request address is 64'h2000.
- Redirect in the same cycle as `imem_rvalid_i` → the data is not pushed, the state is RUN, and `imem_req_o` is high in the next cycle at the redirect PC.
- Memory stall: `imem_ready_i` low for 5 cycles → `imem_addr_o` is held constant and `fetch_pc` does not advance; on acceptance it advances by exactly 4.
- Wrap-around: `RESET_PC` = 64'hFFFF_FFFF_FFFF_FFFC → the second request address is 64'h0.

Source files
------------

// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word request in
// flight to instruction memory and buffers returned words with their PCs for decode.
module riscv_ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic [1:0]  dbg_state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // imem_req_o holds with a fixed address until accepted (only a redirect withdraws
  // it); instr_valid_o holds its head until instr_ready_i consumes it.

  logic [1:0]    state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   pc_mem_q [DEPTH];
  logic [63:0]   pc_mem_d [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];
  logic [31:0]   ins_mem_d [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign imem_req_o    = rst_ni & (state_q == ST_RUN) & ~redirect_i & (count_q < FULL);
  assign imem_addr_o   = rst_ni ? fetch_pc_q : RESET_PC;
  assign instr_valid_o = rst_ni & (count_q != '0) & ~redirect_i;
  assign instr_o       = rst_ni ? ins_mem_q[rd_ptr_q] : 32'h0;
  assign instr_pc_o    = rst_ni ? pc_mem_q[rd_ptr_q] : 64'h0;
  assign dbg_state_o   = state_q;

  assign accept = imem_req_o & imem_ready_i;
  assign push   = ~redirect_i & (state_q == ST_WAIT) & imem_rvalid_i;
  assign pop    = instr_valid_o & instr_ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // An in-flight request must still return before a new one may go out.
      case (state_q)
        ST_WAIT, ST_DROP: state_d = imem_rvalid_i ? ST_RUN : ST_DROP;
        default:          state_d = ST_RUN;
      endcase
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) state_d = ST_RUN;
        end
        ST_DROP: begin
          if (imem_rvalid_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase

      if (push) begin
        pc_mem_d[wr_ptr_q]  = req_pc_q;
        ins_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d            = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Bench for riscv_ifetch: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_riscv_ifetch;

  localparam int          DEPTH   = 2;
  localparam logic [63:0] BOOT_PC = 64'h1000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        instr_ready_i = 1'b0;

  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic [1:0]  dbg_state_o;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [63:0] w_pc;
  logic [1:0]  w_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  riscv_ifetch #(.RESET_PC(BOOT_PC), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .dbg_state_o(dbg_state_o)
  );

  riscv_ifetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_pc),
    .instr_ready_i(instr_ready_i), .dbg_state_o(w_state)
  );

  typedef struct {
    bit          rst_n;
    bit          ready;
    bit          rvalid;
    logic [31:0] rdata;
    bit          redir;
    logic [63:0] rpc;
    bit          iready;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(bit rst_n, bit ready, bit rvalid, logic [31:0] rdata,
                              bit redir, logic [63:0] rpc, bit iready, bit e_req,
                              logic [63:0] e_addr, bit e_valid, logic [63:0] e_pc,
                              logic [31:0] e_instr);
    vec_t v;
    v.rst_n = rst_n; v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
    v.redir = redir; v.rpc = rpc; v.iready = iready; v.e_req = e_req;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_ni        = v.rst_n;
    imem_ready_i  = v.ready;
    imem_rvalid_i = v.rvalid;
    imem_rdata_i  = v.rdata;
    redirect_i    = v.redir;
    redirect_pc_i = v.rpc;
    instr_ready_i = v.iready;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk_i);
    drive(v);
    #1;
    chk({tag, ".req"}, {63'h0, imem_req_o}, {63'h0, v.e_req});
    chk({tag, ".addr"}, imem_addr_o, v.e_addr);
    chk({tag, ".valid"}, {63'h0, instr_valid_o}, {63'h0, v.e_valid});
    if (v.e_valid || !v.rst_n) begin
      chk({tag, ".pc"}, instr_pc_o, v.e_pc);
      chk({tag, ".instr"}, {32'h0, instr_o}, {32'h0, v.e_instr});
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_fpc;
  logic [63:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  logic [95:0] exp_q[$];

  bit          mem_pend;
  int          mem_wait;
  logic [63:0] mem_addr;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[33:2] ^ 32'h1357_9BDF;
  endfunction

  vec_t tbl[12];

  initial begin
    // Boot, back-pressure on a 2-entry queue, then drain and resume.
    tbl[0]  = mk(0,1,0,32'h0,       0,64'h0,0, 0,64'h1000,0,64'h0,   32'h0);
    tbl[1]  = mk(1,1,0,32'h0,       0,64'h0,0, 1,64'h1000,0,64'h0,   32'h0);
    tbl[2]  = mk(1,1,1,32'h00500093,0,64'h0,0, 0,64'h1004,0,64'h0,   32'h0);
    tbl[3]  = mk(1,1,0,32'h0,       0,64'h0,0, 1,64'h1004,1,64'h1000,32'h00500093);
    tbl[4]  = mk(1,1,1,32'h00a00113,0,64'h0,0, 0,64'h1008,1,64'h1000,32'h00500093);
    tbl[5]  = mk(1,1,0,32'h0,       0,64'h0,0, 0,64'h1008,1,64'h1000,32'h00500093);
    tbl[6]  = mk(1,1,0,32'h0,       0,64'h0,0, 0,64'h1008,1,64'h1000,32'h00500093);
    tbl[7]  = mk(1,1,0,32'h0,       0,64'h0,1, 0,64'h1008,1,64'h1000,32'h00500093);
    tbl[8]  = mk(1,1,0,32'h0,       0,64'h0,0, 1,64'h1008,1,64'h1004,32'h00a00113);
    tbl[9]  = mk(1,1,1,32'h00c00193,0,64'h0,1, 0,64'h100c,1,64'h1004,32'h00a00113);
    tbl[10] = mk(1,1,0,32'h0,       0,64'h0,1, 1,64'h100c,1,64'h1008,32'h00c00193);
    tbl[11] = mk(1,1,0,32'h0,       0,64'h0,0, 0,64'h1010,0,64'h0,   32'h0);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
      // The wrap instance sees identical traffic, offset by its reset PC.
      if (i < 4) chk($sformatf("wrap%0d.addr", i), w_addr, tbl[i].e_addr - 64'h1004);
    end

    // Redirect while waiting with a non-empty queue: stale response dropped.
    run_vec(mk(0,1,0,32'h0,       0,64'h0,   0, 0,64'h1000,0,64'h0,32'h0), "rw0");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h1000,0,64'h0,32'h0), "rw1");
    run_vec(mk(1,1,1,32'h11111111,0,64'h0,   0, 0,64'h1004,0,64'h0,32'h0), "rw2");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h1004,1,64'h1000,32'h11111111), "rw3");
    run_vec(mk(1,1,0,32'h0,       1,64'h2002,0, 0,64'h1008,0,64'h0,32'h0), "rw4");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 0,64'h2000,0,64'h0,32'h0), "rw5");
    run_vec(mk(1,1,1,32'h22222222,0,64'h0,   0, 0,64'h2000,0,64'h0,32'h0), "rw6");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h2000,0,64'h0,32'h0), "rw7");
    run_vec(mk(1,1,1,32'h33333333,0,64'h0,   0, 0,64'h2004,0,64'h0,32'h0), "rw8");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h2004,1,64'h2000,32'h33333333), "rw9");

    // Redirect in the same cycle as the response.
    run_vec(mk(0,1,0,32'h0,       0,64'h0,   0, 0,64'h1000,0,64'h0,32'h0), "rv0");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h1000,0,64'h0,32'h0), "rv1");
    run_vec(mk(1,1,1,32'h44444444,1,64'h3001,0, 0,64'h1004,0,64'h0,32'h0), "rv2");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h3000,0,64'h0,32'h0), "rv3");
    run_vec(mk(1,1,1,32'h55555555,0,64'h0,   0, 0,64'h3004,0,64'h0,32'h0), "rv4");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,   0, 1,64'h3004,1,64'h3000,32'h55555555), "rv5");

    // Memory stall for five cycles.
    run_vec(mk(0,0,0,32'h0,0,64'h0,0, 0,64'h1000,0,64'h0,32'h0), "st0");
    for (int i = 1; i <= 5; i++)
      run_vec(mk(1,0,0,32'h0,0,64'h0,0, 1,64'h1000,0,64'h0,32'h0), $sformatf("st%0d", i));
    run_vec(mk(1,1,0,32'h0,0,64'h0,0, 1,64'h1000,0,64'h0,32'h0), "st6");
    run_vec(mk(1,1,0,32'h0,0,64'h0,0, 0,64'h1004,0,64'h0,32'h0), "st7");

    // Reset mid-operation; the late response must be ignored.
    run_vec(mk(0,1,0,32'h0,       0,64'h0,0, 0,64'h1000,0,64'h0,32'h0), "rs0");
    run_vec(mk(1,1,0,32'h0,       0,64'h0,0, 1,64'h1000,0,64'h0,32'h0), "rs1");
    run_vec(mk(0,1,0,32'h0,       0,64'h0,0, 0,64'h1000,0,64'h0,32'h0), "rs2");
    run_vec(mk(1,0,1,32'h66666666,0,64'h0,0, 1,64'h1000,0,64'h0,32'h0), "rs3");
    run_vec(mk(1,0,0,32'h0,       0,64'h0,0, 1,64'h1000,0,64'h0,32'h0), "rs4");

    // Redirect from RUN: new PC requested the next cycle.
    run_vec(mk(0,0,0,32'h0,0,64'h0,   0, 0,64'h1000,0,64'h0,32'h0), "rr0");
    run_vec(mk(1,0,0,32'h0,1,64'h4007,0, 0,64'h1000,0,64'h0,32'h0), "rr1");
    run_vec(mk(1,1,0,32'h0,0,64'h0,   0, 1,64'h4004,0,64'h0,32'h0), "rr2");
    run_vec(mk(1,1,0,32'h0,0,64'h0,   0, 0,64'h4008,0,64'h0,32'h0), "rr3");

    // ---------------- randomized phase ----------------
    run_vec(mk(0,0,0,32'h0,0,64'h0,0, 0,64'h1000,0,64'h0,32'h0), "rnd_rst");
    m_fpc = BOOT_PC; m_req_pc = '0; m_out = 0; m_drop = 0; exp_q.delete();
    mem_pend = 0; mem_wait = 0; mem_addr = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          e_req;
      bit          e_valid;
      logic [95:0] head;
      @(negedge clk_i);
      rst_ni        = 1'b1;
      imem_ready_i  = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 9) == 0);
      redirect_pc_i = {$urandom, $urandom};
      instr_ready_i = $urandom_range(0, 1) == 1;
      if (mem_pend && mem_wait == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mem_addr);
      end else if (!mem_pend && $urandom_range(0, 19) == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = $urandom;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      #1;
      e_req   = !m_out && !redirect_i && (exp_q.size() < DEPTH);
      e_valid = (exp_q.size() != 0) && !redirect_i;
      chk($sformatf("rnd%0d.req", cyc), {63'h0, imem_req_o}, {63'h0, e_req});
      chk($sformatf("rnd%0d.addr", cyc), imem_addr_o, m_fpc);
      chk($sformatf("rnd%0d.valid", cyc), {63'h0, instr_valid_o}, {63'h0, e_valid});
      if (e_valid) begin
        head = exp_q[0];
        chk($sformatf("rnd%0d.pc", cyc), instr_pc_o, head[95:32]);
        chk($sformatf("rnd%0d.instr", cyc), {32'h0, instr_o}, {32'h0, head[31:0]});
      end

      if (imem_rvalid_i) mem_pend = 0;
      else if (mem_pend && mem_wait > 0) mem_wait--;
      if (e_req && imem_ready_i) begin
        mem_pend = 1;
        mem_addr = m_fpc;
        mem_wait = $urandom_range(0, 2);
      end

      if (redirect_i) begin
        m_fpc = {redirect_pc_i[63:2], 2'b00};
        exp_q.delete();
        if (m_out) begin
          if (imem_rvalid_i) m_out = 0;
          else m_drop = 1;
        end
      end else begin
        if (e_valid && instr_ready_i) void'(exp_q.pop_front());
        if (m_out && imem_rvalid_i) begin
          if (!m_drop) exp_q.push_back({m_req_pc, imem_rdata_i});
          m_out = 0;
        end else if (e_req && imem_ready_i) begin
          m_out    = 1;
          m_drop   = 0;
          m_req_pc = m_fpc;
          m_fpc    = m_fpc + 64'd4;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
